// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-addressed SRAM array.
// Registered HREADYOUT/HRESP/HRDATA, programmable wait states, two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slv_hsel_i,
    input  logic [1:0]  slv_htrans_i,
    input  logic [31:0] slv_haddr_i,
    input  logic        slv_hwrite_i,
    input  logic [2:0]  slv_hsize_i,
    input  logic [2:0]  slv_hburst_i,
    input  logic [3:0]  slv_hprot_i,
    input  logic [31:0] slv_hwdata_i,
    input  logic        slv_hready_i,
    output logic        slv_hreadyout_o,
    output logic        slv_hresp_o,
    output logic [31:0] slv_hrdata_o
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [31:0]   MEM_BYTES = 32'(4 * MEM_DEPTH);
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    logic [31:0]   r_mem [MEM_DEPTH];
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [AW+1:0] r_addr, w_addr_nxt;
    logic          r_write, w_write_nxt;
    logic [1:0]    r_size, w_size_nxt;
    logic          r_hreadyout, w_hreadyout_nxt;
    logic          r_hresp, w_hresp_nxt;
    logic [31:0]   r_hrdata, w_hrdata_nxt;

    logic          w_phase_end, w_accept, w_size_bad, w_illegal;
    logic          w_commit;
    logic [3:0]    w_be;
    logic [AW-1:0] w_wr_idx, w_rd_idx;
    logic [31:0]   w_old_word, w_wr_word, w_rd_word;
    logic          w_unused;

    assign w_unused = ^{slv_hburst_i, slv_hprot_i, slv_htrans_i[0]};

    // Address-phase decode and next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_write_nxt = r_write;
        w_size_nxt  = r_size;

        w_phase_end = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                      ((r_state == S_DATA) && (r_cnt == '0));
        w_accept    = w_phase_end && slv_hsel_i && slv_htrans_i[1] && slv_hready_i;

        case (slv_hsize_i)
            3'd0:    w_size_bad = 1'b0;
            3'd1:    w_size_bad = slv_haddr_i[0];
            3'd2:    w_size_bad = |slv_haddr_i[1:0];
            default: w_size_bad = 1'b1;
        endcase
        w_illegal = w_size_bad || (slv_haddr_i >= MEM_BYTES);

        case (r_state)
            S_DATA: begin
                if (r_cnt != '0) w_cnt_nxt   = r_cnt - CW'(1);
                else             w_state_nxt = S_IDLE;
            end
            S_ERR1:  w_state_nxt = S_ERR2;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_accept) begin
            w_state_nxt = w_illegal ? S_ERR1 : S_DATA;
            w_cnt_nxt   = WAIT_INIT;
            w_addr_nxt  = slv_haddr_i[AW+1:0];
            w_write_nxt = slv_hwrite_i;
            w_size_nxt  = slv_hsize_i[1:0];
        end
    end

    // Write merge and read port; a read registered on the same edge as a write to the same word sees the new data
    always_comb begin
        w_commit = (r_state == S_DATA) && (r_cnt == '0) && r_write;
        w_wr_idx = r_addr[AW+1:2];
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_addr[1:0];
            2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
        w_old_word = r_mem[w_wr_idx];
        for (int b = 0; b < 4; b++) begin
            w_wr_word[8*b +: 8] = w_be[b] ? slv_hwdata_i[8*b +: 8] : w_old_word[8*b +: 8];
        end
        w_rd_idx  = w_addr_nxt[AW+1:2];
        w_rd_word = (w_commit && (w_rd_idx == w_wr_idx)) ? w_wr_word : r_mem[w_rd_idx];
    end

    // Output values for the coming cycle
    always_comb begin
        w_hreadyout_nxt = !(((w_state_nxt == S_DATA) && (w_cnt_nxt != '0)) || (w_state_nxt == S_ERR1));
        w_hresp_nxt     = (w_state_nxt == S_ERR1) || (w_state_nxt == S_ERR2);
        w_hrdata_nxt    = ((w_state_nxt == S_DATA) && (w_cnt_nxt == '0) && !w_write_nxt) ? w_rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_write     <= w_write_nxt;
            r_size      <= w_size_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
            r_hrdata    <= w_hrdata_nxt;
        end
    end

    // SRAM array is not reset; a write pending when reset hits is dropped
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) r_mem[w_wr_idx] <= w_wr_word;
    end

    assign slv_hreadyout_o = r_hreadyout;
    assign slv_hresp_o     = r_hresp;
    assign slv_hrdata_o    = r_hrdata;
endmodule
